// File: rtl/dma_ctrl_mc.sv
// dma_ctrl_mc: multi-channel DMA mover between one DRAM and one SRAM port.
// In: clk, reset (async, low), per-channel dmaCmd/Src/Dst/Width, sramReadData,
//     dramReadData, dramValid.
// Out: sramAddress/WriteData/WriteEnable, dramAddress/WriteData/WriteEnable,
//      dramReadEnable, stall[NUM_CH], dmaValid[NUM_CH].
module dma_ctrl_mc #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH_W = 10,
  parameter int SRAM_AW = 14
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2*NUM_CH-1:0]       dmaCmd,
  input  logic [32*NUM_CH-1:0]      dmaSrcAddress,
  input  logic [32*NUM_CH-1:0]      dmaDstAddress,
  input  logic [WIDTH_W*NUM_CH-1:0] dmaWidth,
  input  logic [31:0]               sramReadData,
  input  logic [31:0]               dramReadData,
  input  logic                      dramValid,
  output logic [SRAM_AW-1:0]        sramAddress,
  output logic [31:0]               sramWriteData,
  output logic                      sramWriteEnable,
  output logic [31:0]               dramAddress,
  output logic [31:0]               dramWriteData,
  output logic                      dramWriteEnable,
  output logic                      dramReadEnable,
  output logic [NUM_CH-1:0]         stall,
  output logic [NUM_CH-1:0]         dmaValid
);

  localparam int PW = $clog2(NUM_CH);

  typedef enum logic [2:0] {
    IDLE, RD, WR, SRD, SWR, DONE
  } stateT;

  stateT state, nextState;

  logic [NUM_CH-1:0]  pending;
  logic [NUM_CH-1:0]  chDir;
  logic [31:0]        chSrc   [NUM_CH];
  logic [31:0]        chDst   [NUM_CH];
  logic [WIDTH_W-1:0] chWidth [NUM_CH];

  logic [PW-1:0]      rrPtr;
  logic [PW-1:0]      actCh;
  logic [PW-1:0]      grantCh;
  logic               grantFound;
  logic [31:0]        src;
  logic [31:0]        dst;
  logic [31:0]        word;
  logic               wordValid;
  logic [WIDTH_W-1:0] remaining;
  logic               lastWord;

  assign lastWord = (remaining == WIDTH_W'(1));
  assign stall    = pending;

  // first pending channel scanning upward from rrPtr, wrapping
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    grantFound = 1'b0;
    grantCh    = '0;
    sum        = '0;
    idx        = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, rrPtr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_CH))
        sum = sum - (PW+1)'(NUM_CH);
      idx = sum[PW-1:0];
      if (!grantFound && pending[idx]) begin
        grantFound = 1'b1;
        grantCh    = idx;
      end
    end
  end

  // pending doubles as the stall flag; the active channel
  // stays pending, so its cmd is ignored until DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      chDir   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        chSrc[i]   <= '0;
        chDst[i]   <= '0;
        chWidth[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (state == DONE && actCh == PW'(i)) begin
          pending[i] <= 1'b0;
        end else if (!pending[i] &&
                     (dmaCmd[2*i +: 2] == 2'b01 ||
                      dmaCmd[2*i +: 2] == 2'b10)) begin
          pending[i] <= 1'b1;
          chDir[i]   <= dmaCmd[2*i+1];
          chSrc[i]   <= dmaSrcAddress[32*i +: 32];
          chDst[i]   <= dmaDstAddress[32*i +: 32];
          chWidth[i] <= dmaWidth[WIDTH_W*i +: WIDTH_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= nextState;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rrPtr     <= '0;
      actCh     <= '0;
      src       <= '0;
      dst       <= '0;
      word      <= '0;
      wordValid <= 1'b0;
      remaining <= '0;
    end else begin
      unique case (state)
        IDLE: if (grantFound) begin
          actCh     <= grantCh;
          src       <= chSrc[grantCh];
          dst       <= chDst[grantCh];
          remaining <= chWidth[grantCh];
          rrPtr     <= (grantCh == PW'(NUM_CH-1)) ?
                       '0 : grantCh + PW'(1);
        end
        RD: if (dramValid)
          word <= dramReadData;
        WR: begin
          src       <= src + 32'd4;
          dst       <= dst + 32'd4;
          remaining <= remaining - WIDTH_W'(1);
        end
        SRD: wordValid <= 1'b0;
        // SRAM data shows up in the first SWR cycle; hold it
        // for as long as DRAM keeps us waiting
        SWR: begin
          if (!wordValid) begin
            word      <= sramReadData;
            wordValid <= 1'b1;
          end
          if (dramValid) begin
            src       <= src + 32'd4;
            dst       <= dst + 32'd4;
            remaining <= remaining - WIDTH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState       = state;
    sramAddress     = '0;
    sramWriteData   = '0;
    sramWriteEnable = 1'b0;
    dramAddress     = '0;
    dramWriteData   = '0;
    dramWriteEnable = 1'b0;
    dramReadEnable  = 1'b0;
    dmaValid        = '0;
    unique case (state)
      IDLE: if (grantFound) begin
        if (chWidth[grantCh] == '0)
          nextState = DONE;
        else if (chDir[grantCh])
          nextState = SRD;
        else
          nextState = RD;
      end
      RD: begin
        dramReadEnable = 1'b1;
        dramAddress    = src;
        if (dramValid)
          nextState = WR;
      end
      WR: begin
        sramWriteEnable = 1'b1;
        sramAddress     = dst[SRAM_AW-1:0];
        sramWriteData   = word;
        nextState       = lastWord ? DONE : RD;
      end
      SRD: begin
        sramAddress = src[SRAM_AW-1:0];
        nextState   = SWR;
      end
      SWR: begin
        dramWriteEnable = 1'b1;
        dramAddress     = dst;
        dramWriteData   = wordValid ? word : sramReadData;
        if (dramValid)
          nextState = lastWord ? DONE : SRD;
      end
      DONE: begin
        dmaValid[actCh] = 1'b1;
        nextState       = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_ctrl_mc.sv
// tb_dma_ctrl_mc: directed bench for dma_ctrl_mc with SRAM/DRAM models.
// Drives/samples at negedge+1; DRAM answers after dramDelay cycles.
module tb_dma_ctrl_mc;
  localparam int NC = 4;
  localparam int WW = 10;
  localparam int AW = 14;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [2*NC-1:0]  dmaCmd = '0;
  logic [32*NC-1:0] dmaSrcAddress = '0;
  logic [32*NC-1:0] dmaDstAddress = '0;
  logic [WW*NC-1:0] dmaWidth = '0;
  logic [31:0]    sramReadData = '0;
  logic [31:0]    dramReadData;
  logic           dramValid;
  logic [AW-1:0]  sramAddress;
  logic [31:0]    sramWriteData;
  logic           sramWriteEnable;
  logic [31:0]    dramAddress;
  logic [31:0]    dramWriteData;
  logic           dramWriteEnable;
  logic           dramReadEnable;
  logic [NC-1:0]  stall;
  logic [NC-1:0]  dmaValid;

  dma_ctrl_mc #(.NUM_CH(NC), .WIDTH_W(WW), .SRAM_AW(AW)) dut (
    .clk(clk), .reset(reset),
    .dmaCmd(dmaCmd),
    .dmaSrcAddress(dmaSrcAddress),
    .dmaDstAddress(dmaDstAddress),
    .dmaWidth(dmaWidth),
    .sramReadData(sramReadData),
    .dramReadData(dramReadData),
    .dramValid(dramValid),
    .sramAddress(sramAddress),
    .sramWriteData(sramWriteData),
    .sramWriteEnable(sramWriteEnable),
    .dramAddress(dramAddress),
    .dramWriteData(dramWriteData),
    .dramWriteEnable(dramWriteEnable),
    .dramReadEnable(dramReadEnable),
    .stall(stall),
    .dmaValid(dmaValid)
  );

  initial forever #5 clk = ~clk;

  logic anyOut;
  assign anyOut = |{sramAddress, sramWriteData, sramWriteEnable,
                    dramAddress, dramWriteData, dramWriteEnable,
                    dramReadEnable, stall, dmaValid};

  int nChk = 0;
  int nPass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // SRAM model: synchronous read, bench back-door write port
  logic [31:0] sram [4096];
  logic        tbSramWe = 1'b0;
  logic [11:0] tbSramIdx = '0;
  logic [31:0] tbSramData = '0;

  always @(posedge clk) begin
    if (tbSramWe) sram[tbSramIdx] <= tbSramData;
    else if (sramWriteEnable) sram[sramAddress[13:2]] <= sramWriteData;
    sramReadData <= sram[sramAddress[13:2]];
  end

  function automatic logic [31:0] dramWord(input logic [31:0] a);
    case (a)
      32'd24:  return 32'd1234;
      32'd28:  return 32'd5678;
      32'd32:  return 32'h0000abcd;
      32'd36:  return 32'h0000ef12;
      default: return a ^ 32'h5a5a_0000;
    endcase
  endfunction

  // DRAM model
  int dramDelay = 2;
  int dCnt = 0;
  int wrEnCyc = 0;
  logic [31:0] wrA [$];
  logic [31:0] wrD [$];

  initial begin
    dramValid = 1'b0;
    dramReadData = '0;
    forever begin
      @(negedge clk);
      if (dramReadEnable || dramWriteEnable) begin
        if (dramWriteEnable) wrEnCyc++;
        dCnt++;
        if (dCnt >= dramDelay) begin
          dramValid = 1'b1;
          dCnt = 0;
          if (dramReadEnable) dramReadData = dramWord(dramAddress);
          else begin
            wrA.push_back(dramAddress);
            wrD.push_back(dramWriteData);
          end
        end else dramValid = 1'b0;
      end else begin
        dramValid = 1'b0;
        dCnt = 0;
      end
    end
  end

  // activity monitor
  int srWeCyc = 0;
  int anyEnCyc = 0;
  int exclViol = 0;
  int dvCnt [NC];
  int stallCyc [NC];
  int doneOrder [$];

  initial begin
    for (int i = 0; i < NC; i++) begin
      dvCnt[i] = 0;
      stallCyc[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (sramWriteEnable) srWeCyc++;
      if (sramWriteEnable | dramWriteEnable | dramReadEnable) anyEnCyc++;
      if (32'(sramWriteEnable) + 32'(dramWriteEnable) +
          32'(dramReadEnable) > 1) exclViol++;
      for (int i = 0; i < NC; i++) begin
        if (dmaValid[i]) begin
          dvCnt[i]++;
          doneOrder.push_back(i);
        end
        if (stall[i]) stallCyc[i]++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    dmaCmd = '0;
    tbSramWe = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic setCh(input int ch, input logic [1:0] cmd,
                       input logic [31:0] s, input logic [31:0] d,
                       input logic [WW-1:0] w);
    dmaCmd[2*ch +: 2] = cmd;
    dmaSrcAddress[32*ch +: 32] = s;
    dmaDstAddress[32*ch +: 32] = d;
    dmaWidth[WW*ch +: WW] = w;
  endtask

  task automatic sramPoke(input logic [11:0] idx, input logic [31:0] v);
    tbSramIdx = idx;
    tbSramData = v;
    tbSramWe = 1'b1;
    tick();
    tbSramWe = 1'b0;
  endtask

  task automatic waitDma(input int ch, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (dmaValid[ch]) seen = 1'b1;
    end
    chk($sformatf("done_ch%0d", ch), 64'(seen), 1);
  endtask

  function automatic int orderAt(input int i);
    if (doneOrder.size() > i) return doneOrder[i];
    return -1;
  endfunction

  initial begin
    int a0, a1, a2, a3;
    int o0, err;
    logic [NC-1:0] pendMask;

    // reset state
    tick();
    chk("reset_outs", 64'(anyOut), 0);
    doReset();
    chk("idle_outs", 64'(anyOut), 0);

    // ch0 D2S, 4 words, 5-cycle DRAM latency
    dramDelay = 5;
    a0 = dvCnt[0];
    a1 = srWeCyc;
    setCh(0, 2'b01, 32'd24, 32'd12, 10'd4);
    tick();
    chk("d2s_stall_up", 64'(stall), 4'b0001);
    dmaCmd = '0;
    waitDma(0, 200);
    chk("d2s_stall_at_done", 64'(stall), 4'b0001);
    tick();
    chk("d2s_stall_down", 64'(stall), 0);
    chk("d2s_valid_down", 64'(dmaValid), 0);
    chk("d2s_idle", 64'(anyOut), 0);
    chk("d2s_w12", 64'(sram[3]), 32'd1234);
    chk("d2s_w16", 64'(sram[4]), 32'd5678);
    chk("d2s_w20", 64'(sram[5]), 32'h0000abcd);
    chk("d2s_w24", 64'(sram[6]), 32'h0000ef12);
    chk("d2s_one_pulse", 64'(dvCnt[0] - a0), 1);
    chk("d2s_we_cycles", 64'(srWeCyc - a1), 4);

    // ch1 S2D, 2 words
    doReset();
    sramPoke(12'd0, 32'd7);
    sramPoke(12'd1, 32'd9);
    dramDelay = 3;
    a0 = wrA.size();
    a1 = wrEnCyc;
    setCh(1, 2'b10, 32'd0, 32'd64, 10'd2);
    tick();
    dmaCmd = '0;
    waitDma(1, 100);
    tick();
    chk("s2d_nwr", 64'(wrA.size() - a0), 2);
    if (wrA.size() >= a0 + 2) begin
      chk("s2d_a0", 64'(wrA[a0]), 64);
      chk("s2d_d0", 64'(wrD[a0]), 7);
      chk("s2d_a1", 64'(wrA[a0+1]), 68);
      chk("s2d_d1", 64'(wrD[a0+1]), 9);
    end
    chk("s2d_we_held", 64'(wrEnCyc - a1), 6);

    // address wrap: 32-bit DRAM wrap, SRAM truncation
    doReset();
    dramDelay = 1;
    setCh(0, 2'b01, 32'hFFFF_FFFC, 32'h0001_3FFC, 10'd2);
    tick();
    dmaCmd = '0;
    waitDma(0, 100);
    tick();
    chk("wrap_top", 64'(sram[4095]), 64'(dramWord(32'hFFFF_FFFC)));
    chk("wrap_zero", 64'(sram[0]), 64'(dramWord(32'h0)));

    // simultaneous ch0, ch2, ch3
    doReset();
    dramDelay = 2;
    setCh(0, 2'b01, 32'h100, 32'h200, 10'd1);
    setCh(2, 2'b01, 32'h104, 32'h204, 10'd1);
    setCh(3, 2'b01, 32'h108, 32'h208, 10'd1);
    o0 = doneOrder.size();
    tick();
    chk("rr_stall_latch", 64'(stall), 4'b1101);
    dmaCmd = '0;
    pendMask = 4'b1101;
    err = 0;
    for (int i = 0; i < 300 && pendMask != 0; i++) begin
      tick();
      if (stall !== pendMask) err++;
      pendMask &= ~dmaValid;
    end
    chk("rr_all_done", 64'(pendMask), 0);
    chk("rr_stall_track", 64'(err), 0);
    chk("rr_order0", 64'(orderAt(o0)), 0);
    chk("rr_order1", 64'(orderAt(o0 + 1)), 2);
    chk("rr_order2", 64'(orderAt(o0 + 2)), 3);
    chk("rr_data3", 64'(sram['h208 >> 2]), 64'(dramWord(32'h108)));
    // pointer wrapped to 0: ch0 beats ch1
    o0 = doneOrder.size();
    setCh(0, 2'b01, 32'h110, 32'h210, 10'd1);
    setCh(1, 2'b01, 32'h114, 32'h214, 10'd1);
    tick();
    dmaCmd = '0;
    waitDma(1, 100);
    chk("rr_wrap0", 64'(orderAt(o0)), 0);
    chk("rr_wrap1", 64'(orderAt(o0 + 1)), 1);

    // width 0 on ch2
    doReset();
    a0 = anyEnCyc;
    a1 = stallCyc[2];
    setCh(2, 2'b01, 32'h40, 32'h40, 10'd0);
    tick();
    dmaCmd = '0;
    chk("w0_stall", 64'(stall), 4'b0100);
    chk("w0_no_valid_yet", 64'(dmaValid), 0);
    tick();
    chk("w0_valid", 64'(dmaValid), 4'b0100);
    tick();
    chk("w0_valid_down", 64'(dmaValid), 0);
    chk("w0_stall_down", 64'(stall), 0);
    chk("w0_no_enables", 64'(anyEnCyc - a0), 0);
    chk("w0_stall_len", 64'(stallCyc[2] - a1), 2);

    // reset while waiting in RD
    doReset();
    dramDelay = 100;
    a0 = dvCnt[0];
    setCh(0, 2'b01, 32'h40, 32'h80, 10'd2);
    tick();
    dmaCmd = '0;
    for (int i = 0; i < 20 && !dramReadEnable; i++) tick();
    chk("rst_in_rd", 64'(dramReadEnable), 1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_outs", 64'(anyOut), 0);
    tick();
    tick();
    reset = 1'b1;
    dramDelay = 2;
    tick();
    chk("rst_no_valid", 64'(dvCnt[0] - a0), 0);
    setCh(3, 2'b01, 32'h300, 32'h10, 10'd1);
    tick();
    dmaCmd = '0;
    waitDma(3, 100);
    tick();
    chk("rst_fresh_data", 64'(sram[4]), 64'(dramWord(32'h300)));
    chk("rst_fresh_stall", 64'(stall), 0);

    // cmd 11 ignored; held cmd 01 gives one transfer
    doReset();
    dramDelay = 1;
    a0 = anyEnCyc;
    setCh(1, 2'b11, 32'h500, 32'h40, 10'd2);
    repeat (3) tick();
    chk("c11_stall", 64'(stall), 0);
    chk("c11_no_en", 64'(anyEnCyc - a0), 0);
    a1 = dvCnt[1];
    a2 = srWeCyc;
    a3 = doneOrder.size();
    dmaCmd[3:2] = 2'b01;
    waitDma(1, 100);
    dmaCmd = '0;
    repeat (10) tick();
    chk("c01_once", 64'(dvCnt[1] - a1), 1);
    chk("c01_words", 64'(srWeCyc - a2), 2);
    chk("c01_stall", 64'(stall), 0);
    chk("c01_only_ch1", 64'(doneOrder.size() - a3), 1);
    chk("c01_w0", 64'(sram['h40 >> 2]), 64'(dramWord(32'h500)));
    chk("c01_w1", 64'(sram['h44 >> 2]), 64'(dramWord(32'h504)));

    chk("enables_exclusive", 64'(exclViol), 0);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
